// File: rtl/mem_map_pkg.sv
// Memory map of the MEM-stage data block: peripheral addresses, TCON bit layout
// and the word-address decoder shared by the top level and the bench-facing docs.
package mem_map_pkg;

    localparam logic [31:0] PERIPH_BASE  = 32'h4000_0000;
    localparam logic [31:0] ADDR_TH      = PERIPH_BASE + 32'h00;
    localparam logic [31:0] ADDR_TL      = PERIPH_BASE + 32'h04;
    localparam logic [31:0] ADDR_TCON    = PERIPH_BASE + 32'h08;
    localparam logic [31:0] ADDR_LED     = PERIPH_BASE + 32'h0C;
    localparam logic [31:0] ADDR_SWITCH  = PERIPH_BASE + 32'h10;
    localparam logic [31:0] ADDR_DIGI    = PERIPH_BASE + 32'h14;
    localparam logic [31:0] ADDR_SYSTICK = PERIPH_BASE + 32'h18;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;
    localparam int TCON_W  = 3;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_SWITCH,
        SEL_DIGI,
        SEL_SYSTICK
    } periph_sel_e;

    // Byte-lane bits are dropped before decode: every access is a full word.
    function automatic periph_sel_e periph_decode(input logic [29:0] waddr);
        periph_sel_e sel;
        sel = SEL_NONE;
        if (waddr == ADDR_TH[31:2])      sel = SEL_TH;
        if (waddr == ADDR_TL[31:2])      sel = SEL_TL;
        if (waddr == ADDR_TCON[31:2])    sel = SEL_TCON;
        if (waddr == ADDR_LED[31:2])     sel = SEL_LED;
        if (waddr == ADDR_SWITCH[31:2])  sel = SEL_SWITCH;
        if (waddr == ADDR_DIGI[31:2])    sel = SEL_DIGI;
        if (waddr == ADDR_SYSTICK[31:2]) sel = SEL_SYSTICK;
        return sel;
    endfunction

endpackage

// File: rtl/data_mem_periph_if.sv
// Load/store bus from the EX/MEM pipeline register into the MEM-stage memory block.
// The pipeline side is the master; the memory block answers with combinational load data.
interface data_mem_periph_if;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemRd,
        output MemWr,
        output Address,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  MemRd,
        input  MemWr,
        input  Address,
        input  WriteData,
        output ReadData
    );
endinterface

// File: rtl/timer_unit.sv
// Purpose: reload timer (TH/TL/TCON) with level interrupt request.
// Latency: register writes land on the next edge; IRQ follows TCON with no extra delay.
// Backpressure: none; CPU writes always accepted and override the same-cycle timer update.
module timer_unit
    import mem_map_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_th,
    input  logic              wr_tl,
    input  logic              wr_tcon,
    input  logic [31:0]       wdat,
    output logic [31:0]       th,
    output logic [31:0]       tl,
    output logic [TCON_W-1:0] tcon,
    output logic              irq
);

    logic tl_ovf;

    assign tl_ovf = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_th) begin
                th <= wdat;
            end

            if (wr_tl) begin
                tl <= wdat;
            end else if (tcon[TCON_EN]) begin
                tl <= tl_ovf ? th : tl + 32'd1;
            end

            // A software TCON write drops any overflow status raised on the same edge.
            if (wr_tcon) begin
                tcon <= wdat[TCON_W-1:0];
            end else if (tl_ovf && tcon[TCON_IE]) begin
                tcon[TCON_ST] <= 1'b1;
            end
        end
    end

    assign irq = tcon[TCON_IE] & tcon[TCON_ST];

endmodule

// File: rtl/data_mem_periph.sv
// Purpose: MEM-stage data RAM plus memory-mapped timer, LEDs, switches, 7-seg and systick.
// Latency: loads are combinational (0 cycles); stores commit on the next rising edge.
// Backpressure: none; every load and store completes in the cycle it is presented.
module data_mem_periph
    import mem_map_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int RAM_AW    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    data_mem_periph_if.slave         bus,
    input  logic [7:0]               switch,
    output logic [7:0]               led,
    output logic [11:0]              digi,
    output logic                     IRQ
);

    logic [31:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_hit;
    periph_sel_e       sel;
    logic              unused_addr_lsb;

    logic [31:0]       th;
    logic [31:0]       tl;
    logic [TCON_W-1:0] tcon;
    logic [31:0]       systick;
    logic [31:0]       rdat;

    logic wr_th;
    logic wr_tl;
    logic wr_tcon;

    assign ram_idx         = bus.Address[RAM_AW+1:2];
    assign ram_hit         = (bus.Address[31:RAM_AW+2] == '0);
    assign sel             = periph_decode(bus.Address[31:2]);
    assign unused_addr_lsb = ^bus.Address[1:0];

    assign wr_th   = bus.MemWr && (sel == SEL_TH);
    assign wr_tl   = bus.MemWr && (sel == SEL_TL);
    assign wr_tcon = bus.MemWr && (sel == SEL_TCON);

    timer_unit u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wr_th),
        .wr_tl   (wr_tl),
        .wr_tcon (wr_tcon),
        .wdat    (bus.WriteData),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (IRQ)
    );

    // RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (bus.MemWr && ram_hit) begin
            ram[ram_idx] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led     <= '0;
            digi    <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (bus.MemWr && (sel == SEL_LED)) begin
                led <= bus.WriteData[7:0];
            end
            if (bus.MemWr && (sel == SEL_DIGI)) begin
                digi <= bus.WriteData[11:0];
            end
        end
    end

    always_comb begin
        rdat = '0;
        if (bus.MemRd) begin
            if (ram_hit) begin
                rdat = ram[ram_idx];
            end else begin
                case (sel)
                    SEL_TH:      rdat = th;
                    SEL_TL:      rdat = tl;
                    SEL_TCON:    rdat = {{(32-TCON_W){1'b0}}, tcon};
                    SEL_LED:     rdat = {24'd0, led};
                    SEL_SWITCH:  rdat = {24'd0, switch};
                    SEL_DIGI:    rdat = {20'd0, digi};
                    SEL_SYSTICK: rdat = systick;
                    default:     rdat = '0;
                endcase
            end
        end
    end

    assign bus.ReadData = rdat;

endmodule

// File: doc/data_mem_periph.md
# data_mem_periph

MEM-stage memory block of the pipelined processor. It sits directly downstream of the EX/MEM pipeline register and consumes its MemRd, MemWr, ALUOut (address) and DataBus_B (store data) outputs. It holds a word-addressed data RAM and a memory-mapped peripheral set: a reload timer with interrupt, LEDs, switches, 7-segment digits and a free-running system tick. It returns load data combinationally to the MEM/WB boundary and raises IRQ to the control unit.

## Interface
- RAM_WORDS, 256: data RAM depth in 32-bit words. Must be a power of two.
- RAM_AW, 8: RAM word-address width, log2(RAM_WORDS).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRd  in  1  load enable, from EX/MEM MemRd_out.
- MemWr  in  1  store enable, from EX/MEM MemWr_out.
- Address  in  32  byte address, from EX/MEM ALUOut_out.
- WriteData  in  32  store data, from EX/MEM DataBus_B_out.
- ReadData  out  32  load data (combinational).
- switch  in  8  board switches.
- led  out  8  LED register.
- digi  out  12  7-segment register: [11:8] anode select, [7:0] segments.
- IRQ  out  1  timer interrupt request, level.

## Operation
- Address[1:0] is ignored. All accesses are full words.
- Memory map:
  - RAM: 0x0000_0000 to RAM_WORDS*4-1, indexed by Address[RAM_AW+1:2].
  - TH: 0x4000_0000, 32 bits, read/write.
  - TL: 0x4000_0004, 32 bits, read/write.
  - TCON: 0x4000_0008, 3 bits: [0] enable, [1] irq_en, [2] irq_status.
  - led: 0x4000_000C, 8 bits, read/write.
  - switch: 0x4000_0010, read-only.
  - digi: 0x4000_0014, 12 bits, read/write.
  - systick: 0x4000_0018, 32 bits, read-only.
- Read data:
  - ReadData = selected register or RAM word when MemRd=1, else 0.
  - Unmapped addresses read 0.
  - Narrower registers are zero-extended.
- Writes:
  - Commit on the rising edge when MemWr=1.
  - Writes to unmapped or read-only addresses are ignored.
  - Only the low bits of narrow registers are written.
- Timer, when TCON[0]=1:
  - If TL==0xFFFF_FFFF: TL<=TH, and if TCON[1]=1, set TCON[2]<=1.
  - Otherwise TL<=TL+1 (32-bit).
  - When TCON[0]=0, TL holds.
- IRQ = TCON[1] & TCON[2]. TCON[2] is cleared only by a software write of 0 to bit 2.
- Same-cycle conflicts: a CPU write to TL or TCON beats the timer update. If software writes TCON in the same cycle as an overflow, the written value wins (the overflow status set is lost).
- systick increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
- MemRd=1 and MemWr=1 to the same address: ReadData shows the pre-write value; the new value is visible the next cycle.

## Timing
- Load latency 0: ReadData is valid in the same cycle as Address/MemRd.
- Stores are visible on the cycle after MemWr.
- IRQ asserts one cycle after the overflow edge: the edge that sets TCON[2] makes IRQ high immediately after it.
- Reset (asynchronous assert, synchronous release):
  - TH=0, TL=0, TCON=0, led=0, digi=0, systick=0, IRQ=0.
  - RAM contents are not reset.
- Reset mid-count stops the timer immediately. The timer resumes counting only after software re-enables TCON[0].

## Structure
- Shared package mem_map_pkg holds:
  - address constants: ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED, ADDR_SWITCH, ADDR_DIGI, ADDR_SYSTICK;
  - PERIPH_BASE;
  - TCON bit index constants.
- Sub-module timer_unit holds TH/TL/TCON, the reload logic and IRQ, with write-strobe and data inputs.
- The top level holds the RAM array, led/digi/systick registers and the address decode / read mux.

## Test plan
- Store then load RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both return 0xDEADBEEF. Read 0x0000_0400 -> 0.
- Timer reload: TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=3 -> TL goes FFFF_FFFF, then FFFF_FFFC; TCON reads 7; IRQ=1 on the cycle after reload. Write TCON=3 -> IRQ=0 next cycle.
- Write-vs-count conflict: timer enabled, write TL=0x1234 -> TL reads 0x1234, then 0x1235. Write TCON=3 on the overflow cycle -> TCON=3, IRQ stays 0.
- Peripherals: switch=0xA5 -> load 0x4000_0010 returns 0x0000_00A5. Store 0xFFFF_F3C to digi -> digi=0xF3C. Store to switch or systick -> no change. MemRd=0 -> ReadData=0.
- Reset mid-operation: timer running with IRQ=1, pulse reset low asynchronously between edges -> all registers 0 and IRQ=0 immediately. systick restarts from 0. RAM word written earlier still reads back unchanged.
- systick: read twice 5 cycles apart -> difference of 5. Preload near wrap via force -> wraps to 0.
